// File: rtl/mips_pkg.sv
// mips_pkg: shared mul/div opcodes, HI/LO write-select constant and mul/div FSM states
package mips_pkg;
    localparam logic [1:0] MD_MULT      = 2'b00;
    localparam logic [1:0] MD_MULTU     = 2'b01;
    localparam logic [1:0] MD_DIV       = 2'b10;
    localparam logic [1:0] MD_DIVU      = 2'b11;
    localparam logic [1:0] RHL_SEL_BOTH = 2'b10;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_e;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: magnitude shift-add multiply / restoring divide, iteration counter, sign fixup, result registers
// Ports: load latches operands and clears the counter; iter advances one step;
//        commit writes the sign-fixed result into res_hi/res_lo; last flags the final iteration.
module muldiv_datapath import mips_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             iter,
    input  logic             commit,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH);

    // acc: product high half / partial remainder; sh: multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] acc, sh, mag_b, raw_a;
    logic [CW-1:0]    cnt;
    logic             is_div, neg_q, neg_r, dz;
    logic             signed_op, sa, sb;
    logic [WIDTH:0]   mul_sum, div_t;
    logic [WIDTH-1:0] div_d, div_r, fix_hi, fix_lo;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign sa        = signed_op & rs[WIDTH-1];
    assign sb        = signed_op & rt[WIDTH-1];
    assign last      = cnt == CW'(WIDTH - 1);

    assign mul_sum = {1'b0, acc} + {1'b0, sh[0] ? mag_b : '0};
    assign div_t   = {acc, sh[WIDTH-1]};
    assign div_ge  = div_t >= {1'b0, mag_b};
    // subtraction only kept when div_ge, so the low WIDTH bits are exact
    assign div_d   = div_t[WIDTH-1:0] - mag_b;
    assign div_r   = div_ge ? div_d : div_t[WIDTH-1:0];

    assign prod     = {acc, sh};
    assign prod_fix = neg_q ? -prod : prod;
    // divide by zero bypasses sign fixup: quotient all ones, remainder is the raw dividend
    assign fix_hi = is_div ? (dz ? raw_a : (neg_r ? -acc : acc)) : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo = is_div ? (dz ? '1 : (neg_q ? -sh : sh)) : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            sh     <= '0;
            mag_b  <= '0;
            raw_a  <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            if (load) begin
                acc    <= '0;
                sh     <= sa ? -rs : rs;
                mag_b  <= sb ? -rt : rt;
                raw_a  <= rs;
                cnt    <= '0;
                is_div <= op[1];
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                dz     <= rt == '0;
            end else if (iter) begin
                acc <= is_div ? div_r : mul_sum[WIDTH:1];
                sh  <= is_div ? {sh[WIDTH-2:0], div_ge} : {mul_sum[0], sh[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
            end
            if (commit) begin
                res_hi <= fix_hi;
                res_lo <= fix_lo;
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine producing a HI/LO write and an ID-stage stall request
// Ports: ex_start/ex_op/ex_rs/ex_rt issue an operation (sampled in IDLE); flush aborts;
//        id_hilo_use with busy forms md_stall; rhl_wr strobes res_hi/res_lo with rhl_sel_wr.
module muldiv_unit import mips_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_start,
    input  logic [1:0]       ex_op,
    input  logic [WIDTH-1:0] ex_rs,
    input  logic [WIDTH-1:0] ex_rt,
    input  logic             flush,
    input  logic             id_hilo_use,
    output logic             busy,
    output logic             md_stall,
    output logic             rhl_wr,
    output logic [1:0]       rhl_sel_wr,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    md_state_e state, state_nx;
    logic      load, commit, last;

    assign busy       = state != IDLE;
    assign md_stall   = busy & id_hilo_use;
    assign rhl_sel_wr = RHL_SEL_BOTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rhl_wr <= 1'b0;
        end else begin
            state  <= state_nx;
            rhl_wr <= commit;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: if (ex_start) begin
                state_nx = (ex_op == MD_DIV || ex_op == MD_DIVU) ? DIV : MUL;
                load     = 1'b1;
            end
            MUL, DIV: if (last) state_nx = FIX;
            FIX: begin
                state_nx = IDLE;
                commit   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // flush overrides everything: no start, no result write
        if (flush) begin
            state_nx = IDLE;
            load     = 1'b0;
            commit   = 1'b0;
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .iter   (state == MUL || state == DIV),
        .commit (commit),
        .op     (ex_op),
        .rs     (ex_rs),
        .rt     (ex_rt),
        .last   (last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_start = 1'b0;
    logic [1:0]  ex_op = 2'b00;
    logic [31:0] ex_rs = '0, ex_rt = '0;
    logic        flush = 1'b0;
    logic        id_hilo_use = 1'b0;
    logic        busy, md_stall, rhl_wr;
    logic [1:0]  rhl_sel_wr;
    logic [31:0] res_hi, res_lo;

    typedef struct {logic [63:0] r; int t;} exp_t;
    exp_t        q[$];
    exp_t        ent;
    logic [63:0] last = '0;
    int          errors = 0, checks = 0, ncyc = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_start(ex_start), .ex_op(ex_op), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .flush(flush), .id_hilo_use(id_hilo_use), .busy(busy),
        .md_stall(md_stall), .rhl_wr(rhl_wr), .rhl_sel_wr(rhl_sel_wr),
        .res_hi(res_hi), .res_lo(res_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    // {hi,lo} from plain arithmetic: truncating divide, remainder follows the dividend
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] r;
        if (op == 2'b00)      r = 64'(sa * sb);
        else if (op == 2'b01) r = ua * ub;
        else if (b == 0)      r = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) r = {32'(sa % sb), 32'(sa / sb)};
        else                  r = {32'(ua % ub), 32'(ua / ub)};
        return r;
    endfunction

    function automatic logic [31:0] pick();
        int k = $urandom_range(0, 6);
        return k == 0 ? 32'h0 : k == 1 ? 32'h8000_0000 : k == 2 ? 32'hFFFF_FFFF :
               k == 3 ? 32'h1 : $urandom;
    endfunction

    // called at posedge+1; presents the op for one sampling edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit done);
        exp_t x;
        ex_op = op; ex_rs = a; ex_rt = b; ex_start = 1'b1;
        x.r = model(op, a, b);
        x.t = ncyc;
        if (done) q.push_back(x);
        @(posedge clk); #1 ex_start = 1'b0;
    endtask

    // returns at posedge+1 of the first non-busy cycle (the write cycle)
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        checks++; errors++;
        $display("FAIL timeout busy stuck");
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (rhl_wr) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_wr got=%h_%h exp=none", res_hi, res_lo);
            end else begin
                ent = q.pop_front();
                chk("result", {res_hi, res_lo}, ent.r);
                chk("latency", 64'(ncyc - ent.t - 1), 64'd34);
                chk("sel_wr", {62'b0, rhl_sel_wr}, 64'd2);
                last = ent.r;
            end
        end
    end

    initial begin
        #12;
        chk("rst_busy", {63'b0, busy}, 0);
        chk("rst_wr", {63'b0, rhl_wr}, 0);
        chk("rst_stall", {63'b0, md_stall}, 0);
        chk("rst_res", {res_hi, res_lo}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        chk("busy_c1", {63'b0, busy}, 1);
        wait_idle();
        chk("wr_c34", {63'b0, rhl_wr}, 1);
        issue(2'b00, -32'sd3, 32'd7, 1);          wait_idle();
        issue(2'b10, -32'sd7, 32'd2, 1);          wait_idle();
        issue(2'b11, 32'd100, 32'd0, 1);          wait_idle();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_idle();
        issue(2'b10, 32'hFFFF_FFF0, 32'd0, 1);    wait_idle();

        id_hilo_use = 1'b1;
        issue(2'b00, $urandom, $urandom, 1);
        chk("stall_c1", {63'b0, md_stall}, 1);
        for (int c = 2; c <= 34; c++) begin
            @(posedge clk); #1;
            if (c == 10) begin
                ex_start = 1'b1; ex_op = 2'b11; ex_rs = 32'd5; ex_rt = 32'd1;
            end else ex_start = 1'b0;
            chk("busy_seq", {63'b0, busy}, {63'b0, c <= 33});
            chk("stall_seq", {63'b0, md_stall}, {63'b0, c <= 33});
            if (c == 20) begin
                id_hilo_use = 1'b0;
                #1 chk("stall_comb", {63'b0, md_stall}, 0);
                id_hilo_use = 1'b1;
            end
        end
        chk("wr_stall_cycle", {63'b0, rhl_wr}, 1);
        id_hilo_use = 1'b0;

        @(negedge clk); @(posedge clk); #1;
        issue(2'b10, 32'd100, 32'd7, 0);
        repeat (14) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("flush_keep", {res_hi, res_lo}, last);

        @(posedge clk); #1;
        issue(2'b01, 32'd77, 32'd3, 0);
        repeat (32) @(posedge clk);
        #1 chk("fix_busy", {63'b0, busy}, 1);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("fix_flush_busy", {63'b0, busy}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("fix_flush_keep", {res_hi, res_lo}, last);

        @(posedge clk); #1;
        flush = 1'b1;
        issue(2'b00, 32'd4, 32'd5, 0);
        flush = 1'b0;
        chk("flush_start", {63'b0, busy}, 0);

        issue(2'b01, 32'd2, 32'd3, 1);
        wait_idle();
        issue(2'b11, 32'd9, 32'd4, 1);
        chk("b2b_accept", {63'b0, busy}, 1);
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1);
            wait_idle();
        end

        @(negedge clk);
        @(posedge clk); #1;
        id_hilo_use = 1'b1;
        issue(2'b01, $urandom, $urandom, 0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'b0, busy}, 0);
        chk("arst_stall", {63'b0, md_stall}, 0);
        chk("arst_wr", {63'b0, rhl_wr}, 0);
        chk("arst_res", {res_hi, res_lo}, 0);
        id_hilo_use = 1'b0;
        last = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2'b00, 32'd12345, -32'sd678, 1);
        wait_idle();

        @(negedge clk); #1;
        chk("queue_empty", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide engine in the EX stage. It produces the HI/LO write that the hazard unit's HI/LO forwarding paths consume, and it raises the stall request that holds dependent instructions in ID while an operation is in flight. It accepts one MULT/MULTU/DIV/DIVU per start pulse and returns a 64-bit {hi,lo} result with a one-cycle write strobe. The HI/LO register file and the pipeline stall muxing sit outside this block.

## Interface
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ex_start` input 1: the EX-stage instruction is a mul/div; sampled only in IDLE.
- `ex_op` input 2: operation select.
  - 00 MULT
  - 01 MULTU
  - 10 DIV
  - 11 DIVU
- `ex_rs` input WIDTH: multiplicand / dividend (already forwarded).
- `ex_rt` input WIDTH: multiplier / divisor (already forwarded).
- `flush` input 1: exception/branch cancel; aborts any operation.
- `id_hilo_use` input 1: the ID-stage instruction is MFHI/MFLO/MTHI/MTLO or another mul/div.
- `busy` output 1: operation in flight.
- `md_stall` output 1: stall request to the stall unit, equal to `busy & id_hilo_use`; combinational.
- `rhl_wr` output 1: one-cycle HI/LO write strobe.
- `rhl_sel_wr` output 2: constant 2'b10 (write both HI and LO).
- `res_hi` output WIDTH: HI result, held until the next write.
- `res_lo` output WIDTH: LO result, held until the next write.

## Operation
- States:
  - IDLE
  - MUL: `WIDTH` iterations, radix-2 shift-add on magnitudes.
  - DIV: `WIDTH` iterations, restoring division on magnitudes.
  - FIX: sign fixup and result register load.
- IDLE → MUL or DIV when `ex_start && !flush`. On entry:
  - Latch the operand magnitudes and the sign flags (signed ops only).
  - Clear the iteration counter.
- MUL/DIV → FIX when the counter reaches `WIDTH-1`.
- FIX → IDLE unconditionally.
- `flush` in any state → IDLE next cycle. No `rhl_wr`, and `res_*` are unchanged.
- `ex_start` while not IDLE is ignored. The stall logic prevents it, and the bench checks that it is ignored.
- MULT sign rule: product is negated when the operand signs differ. The 64-bit two's complement result goes to {res_hi,res_lo}.
- DIV/DIVU sign rules:
  - Quotient goes to `res_lo` and is negated when the signs differ.
  - Remainder goes to `res_hi` and takes the sign of the dividend.
- Divide by zero (both DIV and DIVU):
  - `res_lo` = all ones.
  - `res_hi` = `ex_rs` unmodified (no sign fixup).
- Signed overflow 0x80000000 / -1 gives `res_lo`=0x80000000, `res_hi`=0.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - state IDLE
  - `busy` 0
  - `rhl_wr` 0
  - `res_hi` 0
  - `res_lo` 0
  - `md_stall` 0
- Start sampled at edge 0. Then:
  - `busy`=1 from cycle 1 through cycle WIDTH+1 (FIX included).
  - `rhl_wr`=1 for exactly cycle WIDTH+2, with `res_*` valid in that same cycle.
  - `busy`=0 in cycle WIDTH+2.
  - Total latency is 34 cycles for WIDTH=32.
- A new `ex_start` is accepted in the `rhl_wr` cycle, which back-to-back issue needs.
- `md_stall` responds combinationally in the same cycle as `id_hilo_use`.
- `flush` and `ex_start` in the same cycle: flush wins and no operation starts.
- `flush` in FIX: no `rhl_wr`.
- Reset mid-operation: immediate IDLE and the reset values above.

## Structure
- Shared package `mips_pkg` holds:
  - The `ex_op` encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`).
  - The `RHL_SEL_BOTH` = 2'b10 constant used by the hazard unit.
  - The state enum.
- One natural sub-module: `muldiv_datapath`. It owns the shift registers, add/subtract, counter and sign fixup, and is driven by the FSM in `muldiv_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `rhl_wr` at cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Division edge cases:
  - DIVU 100 / 0 → lo=0xFFFFFFFF, hi=100.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Stall:
  - `id_hilo_use`=1 during busy → `md_stall`=1 every busy cycle.
  - `md_stall`=0 in the `rhl_wr` cycle.
  - A second `ex_start` at cycle 10 is ignored.
- Flush behaviour:
  - `flush` at cycle 15 of a DIV → `busy`=0 at cycle 16, no `rhl_wr`, and `res_*` keep their prior values.
  - `flush` together with `ex_start` → no start.
- Back-to-back MULTU 2×3 then DIVU 9/4:
  - The second start is accepted in the first's `rhl_wr` cycle.
  - Results: hi=0, lo=6; then lo=2, hi=1.
- `rst_n` deasserted mid-MUL → all outputs 0 asynchronously; the next start completes normally.
